hilo_unit: RTL and testbench
============================

Name: hilo_unit

Overview:
- Owns the architectural HI/LO register pair of the MIPS datapath.
- Sits directly downstream of the ALU: captures its 64-bit multiply result (ALU_Hi/ALU_Lo) on a product-write strobe.
- Adds the DIV/DIVU capability the ALU lacks, as an iterative restoring divider. Also services MTHI/MTLO.
- Stalls the issue stage through a ready/busy handshake while a divide runs.

Parameters:
- WIDTH, 32, operand/register width.
- DIV_BITS_PER_CYCLE, 1, quotient bits retired per RUN cycle; legal values 1, 2, 4; must divide WIDTH.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- op_valid  in  1  operation presented this cycle.
- op  in  3  0 NOP, 1 WR_PROD, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6-7 reserved.
- alu_hi  in  WIDTH  ALU_Hi from the ALU (used by WR_PROD).
- alu_lo  in  WIDTH  ALU_Lo from the ALU (used by WR_PROD).
- rs_val  in  WIDTH  dividend; also the MTHI/MTLO data.
- rt_val  in  WIDTH  divisor.
- op_ready  out  1  unit can accept an op (= ~busy).
- busy  out  1  divide in progress.
- done  out  1  one-cycle pulse when a divide (including divide-by-zero) completes.
- div_by_zero  out  1  one-cycle pulse, coincident with done, when the divisor was 0.
- hi  out  WIDTH  HI register (registered).
- lo  out  WIDTH  LO register (registered).

Behaviour:
- Reset (asynchronous, reset_n=0): hi=0, lo=0, state=IDLE, busy=0, done=0, div_by_zero=0, all internal datapath regs cleared. Reset mid-divide aborts the divide with no done pulse.
- Accept rule: an op is accepted on a rising edge when op_valid=1 and op_ready=1.
  - op_valid while busy is ignored; the issuer holds the op until op_ready.
  - Reserved ops and NOP are accepted and have no effect.
- WR_PROD: hi<=alu_hi, lo<=alu_lo at the accept edge; visible the next cycle; no busy.
- MTHI: hi<=rs_val. MTLO: lo<=rs_val. Both single-cycle, other register untouched.
- FSM states: IDLE, RUN, FIX.
  - IDLE: DIV/DIVU with rt_val!=0 latches operand magnitudes and sign flags, loads the iteration counter, then goes to RUN.
  - IDLE, divisor 0: DIV/DIVU with rt_val==0 stays in IDLE. done=1 and div_by_zero=1 next cycle; hi/lo unchanged.
  - RUN: lasts WIDTH/DIV_BITS_PER_CYCLE cycles (32 at defaults), each one restoring shift-subtract step per retired bit. Exits to FIX when the counter reaches 0.
  - FIX: applies sign correction, writes lo=quotient and hi=remainder, pulses done, then goes to IDLE.
- Latency at defaults: accept edge E0, RUN edges E1..E32, FIX edge E33. New hi/lo and done are visible after E33; op_ready=1 after E33.
- busy=1 from after E0 until after E33.
- DIVU: unsigned quotient and remainder.
- DIV:
  - Quotient truncates toward zero; remainder takes the sign of the dividend.
  - Computed on magnitudes. Quotient is negated if the operand signs differ; remainder is negated if the dividend is negative.
  - 0x80000000 / 0xFFFFFFFF yields lo=0x80000000, hi=0 (wrap, no trap).
- hi/lo are not modified during RUN. Reads during a divide return the pre-divide values.

Optional Feature:
- Macro HILO_CANCEL_EN.
- When defined: adds input port cancel (1 bit).
  - cancel=1 on a clock edge in RUN or FIX returns to IDLE at that edge.
  - hi/lo are left unchanged, with no done pulse; op_ready=1 next cycle.
  - cancel in IDLE has no effect. cancel has priority over an accepted op in the same cycle.
- When undefined: the port is absent and divides always run to completion.

Decomposition:
- Package hilo_pkg:
  - op encodings (OP_NOP..OP_MTLO).
  - FSM state enum (IDLE, RUN, FIX).
  - counter width constant clog2(WIDTH/DIV_BITS_PER_CYCLE)+1.
- Sub-module hilo_div_step: combinational single-bit restoring step.
  - Inputs: partial remainder, dividend bit, divisor.
  - Outputs: next remainder, quotient bit.
  - Instantiated DIV_BITS_PER_CYCLE times in a chain.

Test Plan:
- Reset: reset_n=0 mid-RUN → hi=0, lo=0, busy=0, done never pulses; after release, MTHI 0x1234 → hi=0x1234 next cycle.
- WR_PROD: alu_hi=0xDEADBEEF, alu_lo=0x01234567 → hi/lo equal these one cycle later; busy stays 0.
- DIVU: rs=100, rt=7 → after 34 cycles lo=14, hi=2, done=1 for one cycle; an op_valid MTLO held during busy is accepted only after op_ready rises.
- DIV signed: rs=-7 (0xFFFFFFF9), rt=2 → lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). Then rs=0x80000000, rt=0xFFFFFFFF → lo=0x80000000, hi=0.
- Divide by zero: hi=5, lo=6, DIV rs=9, rt=0 → done=1 and div_by_zero=1 next cycle, hi=5, lo=6, busy never asserted.
- HILO_CANCEL_EN: DIVU 100/7, cancel pulsed at RUN cycle 10 → hi/lo unchanged, no done, op_ready=1 next cycle.

Source files
------------

// File: rtl/hilo_pkg.sv
// hilo_pkg: op encodings, FSM states and counter sizing shared by the HI/LO unit.
package hilo_pkg;
  typedef enum logic [2:0] {
    OP_NOP, OP_WR_PROD, OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO
  } op_t;
  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
  function automatic int cnt_width(input int w, input int b);
    return $clog2(w / b) + 1;
  endfunction
  localparam int CNT_W = cnt_width(32, 1);
endpackage

// File: rtl/hilo_div_step.sv
// hilo_div_step: one combinational restoring shift-subtract step of the divider.
module hilo_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             dvd_bit,
  input  logic [WIDTH-1:0] dsr,
  output logic [WIDTH-1:0] rem_nx,
  output logic             q_bit
);
  logic [WIDTH:0] t, d;
  assign t = {rem, dvd_bit};
  assign d = t - {1'b0, dsr};
  assign q_bit = ~d[WIDTH];
  assign rem_nx = q_bit ? d[WIDTH-1:0] : t[WIDTH-1:0];
endmodule

// File: rtl/hilo_unit.sv
// hilo_unit: MIPS HI/LO register pair with product capture, MTHI/MTLO and iterative DIV/DIVU.
// Define HILO_CANCEL_EN to add a cancel input that aborts a running divide.
module hilo_unit
  import hilo_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIV_BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             op_valid,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] alu_hi,
  input  logic [WIDTH-1:0] alu_lo,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
`ifdef HILO_CANCEL_EN
  input  logic             cancel,
`endif
  output logic             op_ready,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int B = DIV_BITS_PER_CYCLE;
  localparam int CW = cnt_width(WIDTH, B);
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] dvd, dsr, rem, rs_mag, rt_mag;
  logic neg_q, neg_r, acc, is_div, rs_neg, rt_neg, abort;
  logic [B:0][WIDTH-1:0] rc;
  logic [B-1:0] qb;
`ifdef HILO_CANCEL_EN
  assign abort = cancel && state != IDLE;
`else
  assign abort = 1'b0;
`endif
  assign busy = state != IDLE;
  assign op_ready = ~busy;
  assign acc = op_valid && state == IDLE;
  assign is_div = op == OP_DIV || op == OP_DIVU;
  assign rs_neg = op == OP_DIV && rs_val[WIDTH-1];
  assign rt_neg = op == OP_DIV && rt_val[WIDTH-1];
  assign rs_mag = rs_neg ? -rs_val : rs_val;
  assign rt_mag = rt_neg ? -rt_val : rt_val;
  assign rc[0] = rem;
  for (genvar i = 0; i < B; i++) begin : g_step
    hilo_div_step #(.WIDTH(WIDTH)) u_step (
      .rem(rc[i]), .dvd_bit(dvd[WIDTH-1-i]), .dsr(dsr),
      .rem_nx(rc[i+1]), .q_bit(qb[B-1-i])
    );
  end
  always_comb begin
    state_nx = abort ? IDLE
             : state == IDLE ? ((acc && is_div && rt_val != '0) ? RUN : IDLE)
             : state == RUN  ? (cnt == CW'(1) ? FIX : RUN)
             : IDLE;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hi <= '0;
      lo <= '0;
      dvd <= '0;
      dsr <= '0;
      rem <= '0;
      cnt <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      done <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      div_by_zero <= 1'b0;
      if (!abort) begin
        case (state)
          IDLE: if (acc) begin
            case (op)
              OP_WR_PROD: begin hi <= alu_hi; lo <= alu_lo; end
              OP_MTHI: hi <= rs_val;
              OP_MTLO: lo <= rs_val;
              OP_DIV, OP_DIVU:
                if (rt_val == '0) begin
                  done <= 1'b1;
                  div_by_zero <= 1'b1;
                end else begin
                  dvd <= rs_mag;
                  dsr <= rt_mag;
                  rem <= '0;
                  cnt <= CW'(WIDTH / B);
                  neg_q <= rs_neg ^ rt_neg;
                  neg_r <= rs_neg;
                end
              default: ;
            endcase
          end
          RUN: begin
            rem <= rc[B];
            dvd <= {dvd[WIDTH-B-1:0], qb};
            cnt <= cnt - CW'(1);
          end
          FIX: begin
            lo <= neg_q ? -dvd : dvd;
            hi <= neg_r ? -rem : rem;
            done <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_hilo_unit.sv
// tb_hilo_unit: randomized and directed checks of hilo_unit against an arithmetic reference model.
module tb_hilo_unit;
  import hilo_pkg::*;
  logic clk = 0, reset_n = 0, op_valid = 0;
  logic [2:0] op = 0;
  logic [31:0] alu_hi = 0, alu_lo = 0, rs_val = 0, rt_val = 0;
  logic op_ready, busy, done, div_by_zero;
  logic [31:0] hi, lo;
  logic [31:0] m_hi = 0, m_lo = 0;
  int n_chk = 0, n_pass = 0;
`ifdef HILO_CANCEL_EN
  logic cancel = 0;
`endif
  always #5 clk = ~clk;
  hilo_unit dut (
    .clk(clk), .reset_n(reset_n), .op_valid(op_valid), .op(op),
    .alu_hi(alu_hi), .alu_lo(alu_lo), .rs_val(rs_val), .rt_val(rt_val),
`ifdef HILO_CANCEL_EN
    .cancel(cancel),
`endif
    .op_ready(op_ready), .busy(busy), .done(done), .div_by_zero(div_by_zero),
    .hi(hi), .lo(lo)
  );
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask
  function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [31:0] uq, ur;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q = sa / sb;
      r = sa % sb;
      return {r[31:0], q[31:0]};
    end
    uq = a / b;
    ur = a % b;
    return {ur, uq};
  endfunction
  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
  endtask
  task automatic do_op(input logic [2:0] o, input logic [31:0] rs, input logic [31:0] rt,
                       input logic [31:0] ah, input logic [31:0] al);
    logic [63:0] r;
    int cyc;
    @(negedge clk);
    op_valid = 1; op = o; rs_val = rs; rt_val = rt; alu_hi = ah; alu_lo = al;
    @(negedge clk);
    op_valid = 0;
    if ((o == OP_DIV || o == OP_DIVU) && rt != 0) begin
      r = ref_div(o == OP_DIV, rs, rt);
      check("busy_run", {63'b0, busy}, 64'd1);
      check("hold_hi", {32'b0, hi}, {32'b0, m_hi});
      wait_done(cyc);
      check("div_lat", 64'(cyc), 64'd33);
      check("dbz_clr", {63'b0, div_by_zero}, 64'd0);
      check("ready_end", {63'b0, op_ready}, 64'd1);
      m_hi = r[63:32];
      m_lo = r[31:0];
    end else if (o == OP_DIV || o == OP_DIVU) begin
      check("dbz_done", {62'b0, done, div_by_zero}, 64'd3);
      check("dbz_busy", {63'b0, busy}, 64'd0);
    end else begin
      check("op_flags", {62'b0, done, busy}, 64'd0);
      if (o == OP_WR_PROD) begin m_hi = ah; m_lo = al; end
      if (o == OP_MTHI) m_hi = rs;
      if (o == OP_MTLO) m_lo = rs;
    end
    check("hi", {32'b0, hi}, {32'b0, m_hi});
    check("lo", {32'b0, lo}, {32'b0, m_lo});
  endtask
  initial begin
    int cyc, pulses;
    logic [2:0] o;
    logic [31:0] rt;
    #1;
    check("rst_hilo", {hi, lo}, 64'd0);
    check("rst_flags", {60'b0, busy, done, div_by_zero, op_ready}, 64'd1);
    @(negedge clk);
    reset_n = 1;
    do_op(OP_WR_PROD, 0, 0, 32'hDEADBEEF, 32'h01234567);
    do_op(OP_DIVU, 100, 7, 0, 0);
    check("divu_lo", {32'b0, lo}, 64'd14);
    check("divu_hi", {32'b0, hi}, 64'd2);
    @(negedge clk);
    check("done_pulse", {63'b0, done}, 64'd0);
    do_op(OP_DIV, 32'hFFFFFFF9, 2, 0, 0);
    check("div_neg", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
    do_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 0, 0);
    check("div_wrap", {hi, lo}, 64'h00000000_80000000);
    do_op(OP_MTHI, 5, 0, 0, 0);
    do_op(OP_MTLO, 6, 0, 0, 0);
    do_op(OP_DIV, 9, 0, 0, 0);
    @(negedge clk);
    check("dbz_once", {62'b0, done, div_by_zero}, 64'd0);
    @(negedge clk);
    op_valid = 1; op = OP_DIVU; rs_val = 100; rt_val = 7;
    @(negedge clk);
    op = OP_MTLO; rs_val = 32'hABCD;
    wait_done(cyc);
    check("held_lat", 64'(cyc), 64'd33);
    check("held_prior", {hi, lo}, {32'd2, 32'd14});
    @(negedge clk);
    op_valid = 0;
    m_hi = 2; m_lo = 32'hABCD;
    check("held_mtlo", {hi, lo}, {m_hi, m_lo});
    @(negedge clk);
    op_valid = 1; op = OP_DIVU; rs_val = 100; rt_val = 7;
    @(negedge clk);
    op_valid = 0;
    repeat (10) @(negedge clk);
    reset_n = 0;
    #1;
    check("rst_mid", {hi, lo}, 64'd0);
    check("rst_mid_flags", {62'b0, busy, done}, 64'd0);
    @(negedge clk);
    reset_n = 1;
    m_hi = 0; m_lo = 0;
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) pulses++;
    end
    check("rst_no_done", 64'(pulses), 64'd0);
    do_op(OP_MTHI, 32'h1234, 0, 0, 0);
    check("rst_mthi", {32'b0, hi}, 64'h1234);
`ifdef HILO_CANCEL_EN
    @(negedge clk);
    op_valid = 1; op = OP_DIVU; rs_val = 100; rt_val = 7;
    @(negedge clk);
    op_valid = 0;
    repeat (9) @(negedge clk);
    cancel = 1;
    @(negedge clk);
    cancel = 0;
    check("cxl_ready", {62'b0, op_ready, done}, 64'd2);
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) pulses++;
    end
    check("cxl_no_done", 64'(pulses), 64'd0);
    check("cxl_hilo", {hi, lo}, {m_hi, m_lo});
`endif
    for (int k = 0; k < 24; k++) begin
      o = 3'($urandom_range(0, 7));
      rt = ($urandom_range(0, 5) == 0) ? 32'd0
         : ($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 300)) : $urandom;
      do_op(o, $urandom, rt, $urandom, $urandom);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
